// File: rtl/fmdownsample.sv
// fmdownsample: strided feature-map subsampler; forwards beats of pixels on the X/Y stride grid.
module fmdownsample #(
  parameter int XCOUNTER_BITS = 4,
  parameter int YCOUNTER_BITS = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int SIMD = 2,
  parameter int ELEM_BITS = 8,
  parameter int INIT_XEND = 3,
  parameter int INIT_YEND = 3,
  parameter int INIT_XSTRIDE = 1,
  parameter int INIT_YSTRIDE = 1,
  localparam int STREAM_BITS = 8*(1+(SIMD*ELEM_BITS-1)/8)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   we,
  input  logic [4:0]             wa,
  input  logic [31:0]            wd,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);
  localparam int XB = XCOUNTER_BITS;
  localparam int YB = YCOUNTER_BITS;
  localparam int SF = NUM_CHANNELS/SIMD;
  localparam int SB = SF > 1 ? $clog2(SF) : 1;

  if (NUM_CHANNELS % SIMD != 0) begin : g_bad_fold
    $error("fmdownsample: NUM_CHANNELS must be a multiple of SIMD");
  end
  if (INIT_XEND >= 2**XB || INIT_XSTRIDE >= 2**XB || INIT_YEND >= 2**YB || INIT_YSTRIDE >= 2**YB) begin : g_bad_width
    $error("fmdownsample: counter widths too small for INIT_* values");
  end

  // Config survives ap_rst, so it only has a power-on value.
  logic [XB-1:0] xend = XB'(INIT_XEND);
  logic [XB-1:0] xstride = XB'(INIT_XSTRIDE);
  logic [YB-1:0] yend = YB'(INIT_YEND);
  logic [YB-1:0] ystride = YB'(INIT_YSTRIDE);
  logic unused_wd;
  assign unused_wd = ^wd;

  always_ff @(posedge ap_clk) begin
    if (we) begin
      case (wa)
        5'd0:    xend <= wd[XB-1:0];
        5'd4:    xstride <= wd[XB-1:0];
        5'd8:    yend <= wd[YB-1:0];
        5'd12:   ystride <= wd[YB-1:0];
        default: $error("fmdownsample: illegal config address %0d", wa);
      endcase
    end
  end

  logic [SB-1:0] scnt;
  logic [XB-1:0] xcnt, xph, xlast_ph;
  logic [YB-1:0] ycnt, yph, ylast_ph;
  logic run, a_vld, b_vld, acc, fwd, s_last, x_last, y_last;
  logic [STREAM_BITS-1:0] a_dat, b_dat;

  assign xlast_ph = xstride == '0 ? '0 : xstride - 1'b1;
  assign ylast_ph = ystride == '0 ? '0 : ystride - 1'b1;
  assign s_last = scnt == SB'(SF-1);
  assign x_last = xcnt >= xend;
  assign y_last = ycnt >= yend;
  assign fwd = xph == '0 && yph == '0;
  assign s_axis_tready = run && !a_vld;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = b_vld;
  assign m_axis_tdata = b_dat;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      scnt <= '0;
      xcnt <= '0;
      xph <= '0;
      ycnt <= '0;
      yph <= '0;
    end else if (acc) begin
      scnt <= s_last ? '0 : scnt + 1'b1;
      if (s_last) begin
        xcnt <= x_last ? '0 : xcnt + 1'b1;
        xph <= (x_last || xph >= xlast_ph) ? '0 : xph + 1'b1;
        if (x_last) begin
          ycnt <= y_last ? '0 : ycnt + 1'b1;
          yph <= (y_last || yph >= ylast_ph) ? '0 : yph + 1'b1;
        end
      end
    end
  end

  // run holds tready low until the first edge after reset release.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      run <= 1'b0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
    end else begin
      run <= 1'b1;
      if (!b_vld || m_axis_tready) begin
        b_vld <= a_vld || (acc && fwd);
        a_vld <= 1'b0;
      end else if (acc && fwd) begin
        a_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!b_vld || m_axis_tready)
      b_dat <= a_vld ? a_dat : s_axis_tdata;
    else if (acc && fwd)
      a_dat <= s_axis_tdata;
  end
endmodule

// File: tb/tb_fmdownsample.sv
// tb_fmdownsample: randomized stream bench with a pixel-coordinate reference model.
module tb_fmdownsample;
  localparam int SF = 2;
  logic ap_clk = 0;
  logic ap_rst = 1;
  logic we = 0;
  logic [4:0] wa = '0;
  logic [31:0] wd = '0;
  logic s_axis_tready, s_axis_tvalid = 0, m_axis_tready = 1, m_axis_tvalid;
  logic [15:0] s_axis_tdata = '0, m_axis_tdata;

  fmdownsample #(
    .XCOUNTER_BITS(4), .YCOUNTER_BITS(4), .NUM_CHANNELS(4), .SIMD(2), .ELEM_BITS(8),
    .INIT_XEND(3), .INIT_YEND(3), .INIT_XSTRIDE(1), .INIT_YSTRIDE(1)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .we(we), .wa(wa), .wd(wd),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata)
  );

  always #5 ap_clk = ~ap_clk;

  int passed = 0, total = 0;
  int xe = 3, xsr = 1, ye = 3, ysr = 1;
  int seq = 0, cyc_used = 0;
  int outs[$];
  logic [15:0] q[$];
  logic settled, stall = 0;
  logic [15:0] held;
  int k = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(posedge ap_clk or posedge ap_rst) settled <= !ap_rst;

  // Reference: an accepted beat's frame position gives its pixel; forward iff x and y lie on the stride grid.
  always @(negedge ap_clk) begin
    if (ap_rst || !settled) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tready", s_axis_tready, 0);
      q.delete();
      k = 0;
      stall = 0;
    end else begin
      int pix, x, y, xs, ys;
      chk("tready", s_axis_tready, q.size() < 2);
      chk("tvalid", m_axis_tvalid, q.size() != 0);
      if (stall) chk("hold_data", m_axis_tdata, held);
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) chk("unexpected_out", m_axis_tdata, -1);
        else begin
          chk("data", m_axis_tdata, q[0]);
          void'(q.pop_front());
        end
        outs.push_back(int'(m_axis_tdata));
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      if (s_axis_tvalid && s_axis_tready) begin
        xs = xsr == 0 ? 1 : xsr;
        ys = ysr == 0 ? 1 : ysr;
        pix = k / SF;
        x = pix % (xe + 1);
        y = pix / (xe + 1);
        if (x % xs == 0 && y % ys == 0) q.push_back(s_axis_tdata);
        k = (k + 1) % (SF * (xe + 1) * (ye + 1));
      end
    end
  end

  task automatic wcfg(input logic [4:0] a, input int d);
    we = 1; wa = a; wd = d;
    @(posedge ap_clk); #1;
    we = 0;
    case (a)
      5'd0: xe = d % 16;
      5'd4: xsr = d % 16;
      5'd8: ye = d % 16;
      default: ysr = d % 16;
    endcase
  endtask

  task automatic do_reset();
    @(posedge ap_clk); #1;
    ap_rst = 1; s_axis_tvalid = 0; m_axis_tready = 1;
    #1 chk("rst_async_tvalid", m_axis_tvalid, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 0;
    @(posedge ap_clk); #1;
    outs.delete();
  endtask

  task automatic stream(input int nbeats, input int pv, input int pr);
    int got = 0;
    logic acc;
    cyc_used = 0;
    s_axis_tdata = seq[15:0];
    s_axis_tvalid = $urandom_range(99) < pv;
    m_axis_tready = $urandom_range(99) < pr;
    while (got < nbeats && cyc_used < 5000) begin
      @(negedge ap_clk); acc = s_axis_tvalid && s_axis_tready;
      @(posedge ap_clk); #1;
      cyc_used++;
      if (acc) begin got++; seq++; end
      s_axis_tdata = seq[15:0];
      if (got == nbeats) s_axis_tvalid = 0;
      else if (acc || !s_axis_tvalid) s_axis_tvalid = $urandom_range(99) < pv;
      m_axis_tready = $urandom_range(99) < pr;
    end
    if (got < nbeats) chk("stream_timeout", got, nbeats);
    s_axis_tvalid = 0;
  endtask

  task automatic flush();
    s_axis_tvalid = 0; m_axis_tready = 1;
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_outs(input string nm, input int exp[$]);
    chk({nm, "_count"}, outs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outs.size(); i++) chk(nm, outs[i], exp[i]);
  endtask

  task automatic drive_cycles(input int n, input int rdy_cycles);
    logic acc;
    s_axis_tvalid = 1; s_axis_tdata = seq[15:0]; m_axis_tready = rdy_cycles > 0;
    for (int i = 0; i < n; i++) begin
      @(negedge ap_clk); acc = s_axis_tvalid && s_axis_tready;
      @(posedge ap_clk); #1;
      if (acc) seq++;
      s_axis_tdata = seq[15:0];
      m_axis_tready = i + 1 < rdy_cycles;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    // passthrough
    seq = 0;
    stream(32, 100, 100);
    chk("pass_cycles", cyc_used, 32);
    flush();
    chk("pass_count", outs.size(), 32);
    for (int i = 0; i < 32 && i < outs.size(); i++) chk("pass_beat", outs[i], i);
    // stride 2x2, two frames
    do_reset();
    wcfg(5'd4, 2); wcfg(5'd12, 2);
    seq = 0;
    stream(64, 100, 100);
    flush();
    chk_outs("stride2", '{0, 1, 4, 5, 16, 17, 20, 21, 32, 33, 36, 37, 48, 49, 52, 53});
    // non-divisible width, then stride 0 behaves as 1
    do_reset();
    wcfg(5'd0, 4); wcfg(5'd4, 3); wcfg(5'd8, 0); wcfg(5'd12, 1);
    seq = 0;
    stream(10, 100, 100);
    flush();
    chk_outs("nondiv", '{0, 1, 6, 7});
    wcfg(5'd4, 0);
    outs.delete(); seq = 0;
    stream(10, 100, 100);
    flush();
    chk_outs("stride0", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    // backpressure: two beats held, then input stalls
    do_reset();
    wcfg(5'd0, 3); wcfg(5'd4, 1); wcfg(5'd8, 3); wcfg(5'd12, 1);
    seq = 0;
    drive_cycles(5, 0);
    chk("bp_accepted", seq, 2);
    chk("bp_tready", s_axis_tready, 0);
    chk("bp_outs", outs.size(), 0);
    stream(6, 100, 100);
    flush();
    chk_outs("bp_order", '{0, 1, 2, 3, 4, 5, 6, 7});
    // dropped beats accepted while only B is stalled
    do_reset();
    wcfg(5'd4, 2);
    seq = 0;
    drive_cycles(7, 2);
    chk("drop_accepted", seq, 5);
    chk("drop_tready", s_axis_tready, 0);
    flush();
    chk_outs("drop_order", '{0, 1, 4});
    // mid-frame reset with both registers full; config retained
    do_reset();
    wcfg(5'd4, 1); wcfg(5'd12, 2);
    seq = 0;
    drive_cycles(10, 6);
    chk("mid_accepted", seq, 7);
    chk("mid_full_tready", s_axis_tready, 0);
    chk("mid_full_tvalid", m_axis_tvalid, 1);
    do_reset();
    seq = 100;
    stream(16, 100, 100);
    flush();
    chk_outs("after_reset", '{100, 101, 102, 103, 104, 105, 106, 107});
    // randomized geometry, strides and handshakes
    for (int r = 0; r < 8; r++) begin
      do_reset();
      wcfg(5'd0, $urandom_range(5) | ($urandom_range(1) << 8));
      wcfg(5'd4, $urandom_range(3) | ($urandom_range(1) << 12));
      wcfg(5'd8, $urandom_range(4));
      wcfg(5'd12, $urandom_range(3));
      seq = $urandom_range(20000);
      stream(150 + $urandom_range(150), 40 + $urandom_range(60), 30 + $urandom_range(70));
      flush();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
